req_pend4: RTL and testbench
============================

# req_pend4

Four-requester pending-request tracker that sits directly upstream of the 4-input priority selector. It turns single-cycle request pulses into sticky per-requester outstanding counts and drives the selector's `req`/`en` inputs. It takes the selector's one-hot `gnt` back, retires one outstanding request per accepted grant, and emits a registered issue strobe with the winning index for the downstream consumer.

## Interface
Parameters:
- `CNT_W`, 3: width of each per-requester outstanding counter; saturates at 2^CNT_W−1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_pulse`  in  4  one-cycle request pulses; bit i is requester i (bit 3 is highest priority at the selector).
- `ready`  in  1  downstream can accept an issue this cycle.
- `clr_err`  in  1  synchronous clear of `overflow` and `gnt_err`.
- `gnt`  in  4  one-hot grant returned by the priority selector (combinational from `req`/`en`).
- `req`  out  4  to selector; bit i = (count[i] != 0); registered-derived.
- `en`  out  1  to selector; equals `ready`, combinational.
- `issue_valid`  out  1  registered one-cycle strobe: a grant was accepted last cycle.
- `issue_id`  out  2  index of the accepted grant; valid only with `issue_valid`.
- `pend_cnt`  out  4*CNT_W  concatenated counters, requester i at bits [i*CNT_W +: CNT_W].
- `overflow`  out  4  sticky per requester: pulse arrived while its counter was saturated.
- `gnt_err`  out  1  sticky: illegal grant observed.

## Operation
- State: four CNT_W-bit counters, `issue_valid`/`issue_id` registers, `overflow[3:0]`, `gnt_err`. No explicit FSM; each counter is an independent up/down saturating counter.
- Grant acceptance in cycle t: `en`=1, `gnt` has exactly one bit set, bit k, and `req[k]`=1. Only an accepted grant affects state.
- Per-counter update at each edge, with inc = `req_pulse[i]` and dec = (accepted grant on i):
  - inc & !dec: +1, or hold at max and set `overflow[i]`.
  - !inc & dec: −1.
  - inc & dec: unchanged (no overflow even if at max).
  - neither: hold.
- Illegal grant sets `gnt_err` and does not decrement or issue. Illegal means any of:
  - `gnt` not one-hot and not zero.
  - `gnt` bit set where `req` is 0.
  - `gnt` nonzero while `en`=0.
- `gnt`=0 while `en`=1 is legal when `req`=0. When `req`≠0 it is illegal and sets `gnt_err`.
- `clr_err`=1 clears `overflow` and `gnt_err` at the edge. If an error event occurs in the same cycle, set wins.
- Counter arithmetic is unsigned CNT_W-bit with no wrap: never below 0, never above max.

## Timing
- Reset (rst_n=0, async, immediate): all counters 0, `req`=0, `issue_valid`=0, `issue_id`=0, `overflow`=0, `gnt_err`=0. Reset mid-operation drops all pending requests; no issue is emitted for them.
- Pulse at cycle t: counter and `req[i]` update at t+1.
- Accepted grant at cycle t: `issue_valid`=1 and `issue_id`=k during t+1 only; counter decrement visible at t+1.
- Minimum latency from pulse to `issue_valid` is 2 cycles. Sustained throughput is one issue per cycle while `ready`=1 and any counter is nonzero.
- `issue_valid` deasserts in the cycle after a non-accepted cycle. It never holds for two cycles off a single grant.
- `en` has zero latency from `ready`; there is no registered stage on the `req`→`gnt`→accept path.

## Test plan
- Reset/idle: hold `rst_n`=0, release, no pulses, `ready`=1 → `req`=0, `issue_valid`=0, `pend_cnt`=0, flags 0 for 10 cycles.
- Single request: pulse bit 1 at t0, `ready`=1, selector model returns `gnt`=4'b0010 → `req`=4'b0010 at t0+1, `issue_valid`=1 with `issue_id`=1 at t0+2, `pend_cnt[1]` back to 0.
- Priority/backlog: pulse 4'b1111 once and bit 0 three times, `ready`=1 → issues with ids 3,2,1,0,0,0 on consecutive cycles, then `req`=0.
- Saturation: `CNT_W`=3, `ready`=0, 9 pulses on bit 2 → `pend_cnt[2]`=7, `overflow`=4'b0100. Simultaneous pulse+accepted grant on bit 2 at max → count stays 7, no new overflow.
- Illegal grants: drive `gnt`=4'b0011, then `gnt`=4'b1000 with `req[3]`=0, then `gnt`≠0 with `ready`=0 → `gnt_err`=1, no `issue_valid`, counts unchanged. `clr_err` → `gnt_err`=0 next cycle.
- Async reset mid-burst: counts {2,1,3,0}, assert `rst_n`=0 between edges → all outputs 0 immediately, no issue after release.

Source files
------------

// File: rtl/req_pend4.sv
// req_pend4: per-requester pending-request tracker that sits in front of a
// 4-input priority selector. Request pulses become saturating outstanding
// counts, each accepted grant retires one request and produces a registered
// issue strobe carrying the winning index.
module req_pend4 #(
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_pulse,
    input  logic                 ready,
    input  logic                 clr_err,
    input  logic [3:0]           gnt,
    output logic [3:0]           req,
    output logic                 en,
    output logic                 issue_valid,
    output logic [1:0]           issue_id,
    output logic [4*CNT_W-1:0]   pend_cnt,
    output logic [3:0]           overflow,
    output logic                 gnt_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       gnt_nonzero;
    logic       gnt_onehot;
    logic       gnt_hits_idle;
    logic       accept;
    logic       illegal;
    logic [1:0] gnt_idx;
    logic [3:0] ovf_set;

    logic       issue_valid_q, issue_valid_d;
    logic [1:0] issue_id_q, issue_id_d;
    logic [3:0] overflow_q, overflow_d;
    logic       gnt_err_q, gnt_err_d;

    // The selector sees the enable with zero latency.
    assign en = ready;

    // Classify the returned grant: accepted, illegal, or an idle zero grant.
    assign gnt_nonzero   = (gnt != 4'd0);
    assign gnt_onehot    = gnt_nonzero && ((gnt & (gnt - 4'd1)) == 4'd0);
    assign gnt_hits_idle = |(gnt & ~req);
    assign accept        = ready && gnt_onehot && !gnt_hits_idle;
    assign illegal       = (gnt_nonzero && !gnt_onehot)
                         || gnt_hits_idle
                         || (gnt_nonzero && !ready)
                         || (ready && !gnt_nonzero && (req != 4'd0));

    // Binary index of the one-hot grant; only meaningful when accepted.
    always_comb begin
        gnt_idx = 2'd0;
        unique casez (gnt)
            4'b1???: gnt_idx = 2'd3;
            4'b01??: gnt_idx = 2'd2;
            4'b001?: gnt_idx = 2'd1;
            default: gnt_idx = 2'd0;
        endcase
    end

    // One independent saturating up/down counter per requester.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic             inc;
            logic             dec;
            logic             at_max;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            assign inc         = req_pulse[gi];
            assign dec         = accept && gnt[gi];
            assign at_max      = (cnt_q == CNT_MAX);
            assign ovf_set[gi] = inc && !dec && at_max;

            // Next count: simultaneous pulse and grant cancel out.
            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec && !at_max) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!inc && dec && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            // Counter register; reset drops every outstanding request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign req[gi]                      = (cnt_q != '0);
            assign pend_cnt[gi*CNT_W +: CNT_W]  = cnt_q;
        end
    endgenerate

    // Issue strobe and sticky flags; a new error event beats a clear.
    always_comb begin
        issue_valid_d = accept;
        issue_id_d    = accept ? gnt_idx : issue_id_q;
        overflow_d    = ovf_set | (clr_err ? 4'd0 : overflow_q);
        gnt_err_d     = illegal || (gnt_err_q && !clr_err);
    end

    // Issue and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_id_q    <= 2'd0;
            overflow_q    <= 4'd0;
            gnt_err_q     <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            overflow_q    <= overflow_d;
            gnt_err_q     <= gnt_err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_id    = issue_id_q;
    assign overflow    = overflow_q;
    assign gnt_err     = gnt_err_q;

endmodule

// File: tb/tb_req_pend4.sv
// Testbench for req_pend4: directed scenarios plus a randomized run, all
// checked against a count-based reference model of the tracker.
module tb_req_pend4;

    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_pulse;
    logic              ready;
    logic              clr_err;
    logic [3:0]        gnt;
    logic [3:0]        req;
    logic              en;
    logic              issue_valid;
    logic [1:0]        issue_id;
    logic [4*CNT_W-1:0] pend_cnt;
    logic [3:0]        overflow;
    logic              gnt_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_cnt[4];
    bit         m_iv;
    int         m_id;
    logic [3:0] m_ovf;
    bit         m_err;

    req_pend4 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_pulse(req_pulse), .ready(ready),
        .clr_err(clr_err), .gnt(gnt), .req(req), .en(en),
        .issue_valid(issue_valid), .issue_id(issue_id), .pend_cnt(pend_cnt),
        .overflow(overflow), .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] > 0);
        return r;
    endfunction

    function automatic logic [4*CNT_W-1:0] model_pend();
        logic [4*CNT_W-1:0] p;
        for (int i = 0; i < 4; i++) p[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_iv = 0; m_id = 0; m_ovf = 4'd0; m_err = 0;
    endtask

    // One clock: drive inputs, emulate the selector (or force a grant),
    // advance the model, then land 1 time unit after the edge.
    task automatic cycle(input logic [3:0] pulse, input logic rdy, input logic clr,
                         input bit force_en, input logic [3:0] force_val);
        logic [3:0] mreq, g, oset;
        bit acc, ill, inc, dec;
        int k;
        mreq = model_req();
        g = 4'd0;
        if (force_en) g = force_val;
        else if (rdy) begin
            for (int i = 3; i >= 0; i--) if (mreq[i] && g == 4'd0) g = 4'b0001 << i;
        end
        req_pulse = pulse; ready = rdy; clr_err = clr; gnt = g;
        ill = 0;
        if (g != 0 && $countones(g) != 1) ill = 1;
        if ((g & ~mreq) != 0) ill = 1;
        if (g != 0 && !rdy) ill = 1;
        if (rdy && g == 0 && mreq != 0) ill = 1;
        acc = rdy && ($countones(g) == 1) && ((g & mreq) != 0);
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        oset = 4'd0;
        for (int i = 0; i < 4; i++) begin
            inc = pulse[i];
            dec = acc && g[i];
            if (inc && !dec) begin
                if (m_cnt[i] == MAXC) oset[i] = 1'b1;
                else m_cnt[i]++;
            end else if (!inc && dec) begin
                m_cnt[i]--;
            end
        end
        m_ovf = clr ? oset : (m_ovf | oset);
        m_err = ill ? 1'b1 : (clr ? 1'b0 : m_err);
        m_iv  = acc;
        if (acc) m_id = k;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_pulse = 0; ready = 0; clr_err = 0; gnt = 0;
        model_reset();
        #2;
        checks++;
        if ({req, issue_valid, pend_cnt, overflow, gnt_err} !== '0) begin
            errors++;
            $display("FAIL reset_async: got req=%b iv=%b pend=%h ovf=%b err=%b, want all 0",
                     req, issue_valid, pend_cnt, overflow, gnt_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle(4'd0, 1'b1, 1'b0, 0, 4'd0);
            checks++;
            if ({req, issue_valid, pend_cnt, overflow, gnt_err} !== '0) begin
                errors++;
                $display("FAIL idle_c%0d: got req=%b iv=%b pend=%h ovf=%b err=%b, want all 0",
                         c, req, issue_valid, pend_cnt, overflow, gnt_err);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        cycle(4'b0010, 1'b1, 1'b0, 0, 4'd0);
        checks++;
        if (req !== 4'b0010 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_req: got req=%b iv=%b, want req=0010 iv=0", req, issue_valid);
        end
        cycle(4'd0, 1'b1, 1'b0, 0, 4'd0);
        checks++;
        if (issue_valid !== 1'b1 || issue_id !== 2'd1 || pend_cnt !== '0) begin
            errors++;
            $display("FAIL single_issue: got iv=%b id=%0d pend=%h, want iv=1 id=1 pend=0",
                     issue_valid, issue_id, pend_cnt);
        end
        cycle(4'd0, 1'b1, 1'b0, 0, 4'd0);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_once: got iv=%b, want 0", issue_valid);
        end
        $display("test_single done");
    endtask

    task automatic test_backlog();
        int ids[$];
        int want[6] = '{3, 2, 1, 0, 0, 0};
        cycle(4'b1111, 1'b1, 1'b0, 0, 4'd0);
        for (int c = 0; c < 9; c++) begin
            cycle((c < 2) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, 0, 4'd0);
            if (c < 6) begin
                checks++;
                if (issue_valid !== 1'b1 || int'(issue_id) !== want[c]) begin
                    errors++;
                    $display("FAIL backlog_issue%0d: got iv=%b id=%0d, want iv=1 id=%0d",
                             c, issue_valid, issue_id, want[c]);
                end
            end
            if (issue_valid) ids.push_back(int'(issue_id));
        end
        checks++;
        if (ids.size() != 6 || req !== 4'd0) begin
            errors++;
            $display("FAIL backlog_drain: got issues=%0d req=%b, want issues=6 req=0000",
                     ids.size(), req);
        end
        $display("test_backlog done");
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 9; c++) cycle(4'b0100, 1'b0, 1'b0, 0, 4'd0);
        checks++;
        if (pend_cnt[2*CNT_W +: CNT_W] !== 3'd7 || overflow !== 4'b0100) begin
            errors++;
            $display("FAIL sat_count: got cnt2=%0d ovf=%b, want cnt2=7 ovf=0100",
                     pend_cnt[2*CNT_W +: CNT_W], overflow);
        end
        cycle(4'd0, 1'b0, 1'b1, 0, 4'd0);
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL sat_clr: got ovf=%b, want 0000", overflow);
        end
        cycle(4'b0100, 1'b1, 1'b0, 0, 4'd0);
        checks++;
        if (pend_cnt[2*CNT_W +: CNT_W] !== 3'd7 || overflow !== 4'b0000
            || issue_valid !== 1'b1 || issue_id !== 2'd2) begin
            errors++;
            $display("FAIL sat_incdec: got cnt2=%0d ovf=%b iv=%b id=%0d, want 7 0000 1 2",
                     pend_cnt[2*CNT_W +: CNT_W], overflow, issue_valid, issue_id);
        end
        for (int c = 0; c < 7; c++) cycle(4'd0, 1'b1, 1'b0, 0, 4'd0);
        checks++;
        if (pend_cnt !== '0 || req !== 4'd0) begin
            errors++;
            $display("FAIL sat_drain: got pend=%h req=%b, want 0", pend_cnt, req);
        end
        $display("test_saturation done");
    endtask

    task automatic test_illegal();
        logic [3:0]         fv[4] = '{4'b0011, 4'b1000, 4'b0001, 4'b0000};
        logic               fr[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [4*CNT_W-1:0] pend_before;
        cycle(4'b0011, 1'b0, 1'b0, 0, 4'd0);
        pend_before = model_pend();
        for (int c = 0; c < 4; c++) begin
            cycle(4'd0, fr[c], 1'b0, 1, fv[c]);
            checks++;
            if (gnt_err !== 1'b1 || issue_valid !== 1'b0 || pend_cnt !== pend_before) begin
                errors++;
                $display("FAIL illegal%0d: got err=%b iv=%b pend=%h, want err=1 iv=0 pend=%h",
                         c, gnt_err, issue_valid, pend_cnt, pend_before);
            end
            cycle(4'd0, 1'b0, 1'b1, 0, 4'd0);
            checks++;
            if (gnt_err !== 1'b0) begin
                errors++;
                $display("FAIL illegal_clr%0d: got err=%b, want 0", c, gnt_err);
            end
        end
        // Clear and a new error in the same cycle: the error wins.
        cycle(4'd0, 1'b1, 1'b1, 1, 4'b0110);
        checks++;
        if (gnt_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_setwins: got err=%b, want 1", gnt_err);
        end
        for (int c = 0; c < 2; c++) cycle(4'd0, 1'b1, 1'b1, 0, 4'd0);
        $display("test_illegal done");
    endtask

    task automatic test_async_reset();
        cycle(4'b0101, 1'b0, 1'b0, 0, 4'd0);
        cycle(4'b0111, 1'b0, 1'b0, 0, 4'd0);
        cycle(4'b0100, 1'b0, 1'b0, 0, 4'd0);
        checks++;
        if (pend_cnt !== model_pend() || model_pend() !== 12'b000_011_001_010) begin
            errors++;
            $display("FAIL areset_setup: got pend=%h, want %h", pend_cnt, model_pend());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({req, issue_valid, pend_cnt, overflow, gnt_err} !== '0) begin
            errors++;
            $display("FAIL areset_now: got req=%b iv=%b pend=%h ovf=%b err=%b, want all 0",
                     req, issue_valid, pend_cnt, overflow, gnt_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(4'd0, 1'b1, 1'b0, 0, 4'd0);
            checks++;
            if (issue_valid !== 1'b0 || req !== 4'd0) begin
                errors++;
                $display("FAIL areset_after%0d: got iv=%b req=%b, want 0", c, issue_valid, req);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic [3:0] p, fv;
        logic       r, cl;
        bit         fe;
        for (int c = 0; c < 400; c++) begin
            p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            r  = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 9) == 0);
            fe = ($urandom_range(0, 11) == 0);
            fv = 4'($urandom);
            cycle(p, r, cl, fe, fv);
            checks++;
            if (req !== model_req() || en !== r || issue_valid !== m_iv
                || (m_iv && int'(issue_id) !== m_id) || pend_cnt !== model_pend()
                || overflow !== m_ovf || gnt_err !== m_err) begin
                errors++;
                $display("FAIL random_c%0d: got req=%b en=%b iv=%b id=%0d pend=%h ovf=%b err=%b; want req=%b en=%b iv=%b id=%0d pend=%h ovf=%b err=%b",
                         c, req, en, issue_valid, issue_id, pend_cnt, overflow, gnt_err,
                         model_req(), r, m_iv, m_id, model_pend(), m_ovf, m_err);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backlog();
        test_saturation();
        test_illegal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
